// File: rtl/sseg_sched_pkg.sv
// sseg_sched_pkg: shared types for the seven-segment display scheduler.
// Slot field widths, driver display modes and the scheduler state encoding.
package sseg_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_SHOW
  } state_t;

  localparam int CNT1_W = 14;
  localparam int CNT2_W = 7;
  localparam int DP_W   = 3;

  localparam logic [1:0] MODE_U8   = 2'd0;
  localparam logic [1:0] MODE_2X99 = 2'd1;
  localparam logic [1:0] MODE_U14  = 2'd2;

  typedef struct packed {
    logic [CNT1_W-1:0] cnt1;
    logic [CNT2_W-1:0] cnt2;
    logic [1:0]        mode;
    logic              sign;
    logic [DP_W-1:0]   dp;
  } slot_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
// Returns the first set req scanning upward from ptr+1 with wrap.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [W-1:0] j;

  // Scan from the far end so the nearest hit overwrites
  always_comb begin
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = N; k >= 1; k--) begin
      j = W'((int'(ptr) + k) % N);
      if (req[j]) begin
        idx   = j;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sseg_display_sched.sv
// sseg_display_sched: time-shares one 4-digit display between N_REQ slots.
// Define SSEG_SCHED_BLINK_EN to blink the display during an urgent hold.
module sseg_display_sched
  import sseg_sched_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic                     urgent,
  input  logic [CNT1_W*N_REQ-1:0]  cnt1_bus,
  input  logic [CNT2_W*N_REQ-1:0]  cnt2_bus,
  input  logic [2*N_REQ-1:0]       mode_bus,
  input  logic [N_REQ-1:0]         sign_bus,
  input  logic [DP_W*N_REQ-1:0]    dp_bus,
  output logic [CNT1_W-1:0]        cnt1,
  output logic [CNT2_W-1:0]        cnt2,
  output logic [1:0]               mod_sel,
  output logic                     sign,
  output logic                     dp_en,
  output logic [1:0]               dp_sel,
  output logic                     valid,
  output logic [N_REQ-1:0]         grant,
  output logic [2:0]               owner
);

  localparam int SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DW = $clog2(DWELL_CYCLES);
  localparam logic [DW-1:0] DEND = DW'(DWELL_CYCLES - 1);

  state_t           state, state_n;
  logic [SW-1:0]    rr_ptr, ptr_n, own_i, rr_idx, pick;
  logic [DW-1:0]    dwell_cnt, dwell_n;
  logic [N_REQ-1:0] grant_n;
  logic [2:0]       owner_n;
  logic             valid_n, rr_found, found, urg0;
  slot_t            slot [N_REQ];
  slot_t            fld, fld_n;

`ifdef SSEG_SCHED_BLINK_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BEND = BW'(BLINK_CYCLES - 1);
  logic [BW-1:0] blink_cnt, blink_n;
`else
  logic unused_blink;
  assign unused_blink = (BLINK_CYCLES > 0);
`endif

  for (genvar g = 0; g < N_REQ; g++) begin : g_slot
    assign slot[g] = {cnt1_bus[g*CNT1_W +: CNT1_W],
                      cnt2_bus[g*CNT2_W +: CNT2_W],
                      mode_bus[g*2 +: 2],
                      sign_bus[g],
                      dp_bus[g*DP_W +: DP_W]};
  end

  assign own_i = owner[SW-1:0];
  assign urg0  = urgent & req[0];

  rr_pick #(.N(N_REQ), .W(SW)) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .idx   (rr_idx),
    .found (rr_found)
  );

  assign pick  = urg0 ? '0 : rr_idx;
  assign found = urg0 | rr_found;

  always_comb begin
    state_n = state;
    ptr_n   = rr_ptr;
    dwell_n = dwell_cnt;
    grant_n = grant;
    owner_n = owner;
    valid_n = valid;
    fld_n   = fld;
`ifdef SSEG_SCHED_BLINK_EN
    blink_n = blink_cnt;
`endif
    unique case (state)
      S_IDLE: if (|req) state_n = S_ARB;
      S_ARB: begin
        if (found) begin
          state_n = S_SHOW;
          owner_n = 3'(pick);
          grant_n = N_REQ'(1) << pick;
          fld_n   = slot[pick];
          valid_n = 1'b1;
          dwell_n = '0;
`ifdef SSEG_SCHED_BLINK_EN
          blink_n = '0;
`endif
        end else begin
          state_n = S_IDLE;
          grant_n = '0;
          owner_n = '0;
          valid_n = 1'b0;
        end
      end
      S_SHOW: begin
        fld_n = slot[own_i];
        // Exits keep valid so the last frame stays up through ARB
        if (!req[own_i] || (urg0 && own_i != '0)) begin
          state_n = S_ARB;
          grant_n = '0;
        end else if (own_i == '0 && urgent) begin
          dwell_n = '0;
`ifdef SSEG_SCHED_BLINK_EN
          if (blink_cnt == BEND) begin
            blink_n = '0;
            valid_n = ~valid;
          end else begin
            blink_n = blink_cnt + BW'(1);
          end
`endif
        end else begin
          valid_n = 1'b1;
`ifdef SSEG_SCHED_BLINK_EN
          blink_n = '0;
`endif
          if (dwell_cnt != DEND) begin
            dwell_n = dwell_cnt + DW'(1);
          end else begin
            dwell_n = '0;
            if (|(req & ~grant)) begin
              ptr_n   = own_i;
              state_n = S_ARB;
              grant_n = '0;
            end
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= SW'(N_REQ - 1);
      dwell_cnt <= '0;
      grant     <= '0;
      owner     <= '0;
      valid     <= 1'b0;
      fld       <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= ptr_n;
      dwell_cnt <= dwell_n;
      grant     <= grant_n;
      owner     <= owner_n;
      valid     <= valid_n;
      fld       <= fld_n;
    end
  end

`ifdef SSEG_SCHED_BLINK_EN
  always_ff @(posedge clk) begin
    if (rst) blink_cnt <= '0;
    else     blink_cnt <= blink_n;
  end
`endif

  assign cnt1    = fld.cnt1;
  assign cnt2    = fld.cnt2;
  assign mod_sel = fld.mode;
  assign sign    = fld.sign;
  assign dp_en   = fld.dp[2];
  assign dp_sel  = fld.dp[1:0];

endmodule
